// File: rtl/score_gather.sv
// score_gather: collects four class-score beats into a frame and holds it for
// the classifier stage until handed off.
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_valid/i_data/i_last : inbound score beats (class 0 first), o_in_ready back
//   o_valid/i_ready       : outbound frame handshake
//   o_data_0..o_data_3    : held class scores 0..3
//   o_err                 : one-cycle pulse on a short or long frame
module score_gather #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_in_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data_0,
  output logic [DATA_W-1:0] o_data_1,
  output logic [DATA_W-1:0] o_data_2,
  output logic [DATA_W-1:0] o_data_3,
  output logic              o_err
);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              drain_q, drain_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              in_ready_q, in_ready_d;
  // Slots 0..2 are shadowed so a short frame never disturbs the held output.
  logic [DATA_W-1:0] slot0_q, slot0_d, slot1_q, slot1_d, slot2_q, slot2_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d, data3_q, data3_d;
  logic              accept;

  assign accept = i_valid & in_ready_q;

  // Next-state and output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    slot2_d = slot2_q;
    data0_d = data0_q;
    data1_d = data1_q;
    data2_d = data2_q;
    data3_d = data3_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (cnt_q == 2'd3) begin
            data0_d = slot0_q;
            data1_d = slot1_q;
            data2_d = slot2_q;
            data3_d = i_data;
            cnt_d   = 2'd0;
            state_d = ST_HOLD;
            valid_d = 1'b1;
            // Missing i_last on beat 4: present the frame, then drain the tail.
            if (!i_last) begin
              err_d   = 1'b1;
              drain_d = 1'b1;
            end
          end else if (i_last) begin
            cnt_d = 2'd0;
            err_d = 1'b1;
          end else begin
            case (cnt_q)
              2'd0:    slot0_d = i_data;
              2'd1:    slot1_d = i_data;
              default: slot2_d = i_data;
            endcase
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      ST_HOLD: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (drain_q) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_DRAIN: begin
        if (accept && i_last) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
    in_ready_d = (state_d != ST_HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      cnt_q      <= 2'd0;
      drain_q    <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
      slot0_q    <= '0;
      slot1_q    <= '0;
      slot2_q    <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      data3_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      slot2_q    <= slot2_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      data3_q    <= data3_d;
    end
  end

  assign o_in_ready = in_ready_q;
  assign o_valid    = valid_q;
  assign o_err      = err_q;
  assign o_data_0   = data0_q;
  assign o_data_1   = data1_q;
  assign o_data_2   = data2_q;
  assign o_data_3   = data3_q;

endmodule
